cp0_regfile: RTL
================

Name: cp0_regfile

Overview:
- Coprocessor-0 register file, downstream of the exception priority encoder in the MEM stage.
- Consumes its 32-bit exception type code and performs the architectural side effects:
  - exception entry updates EPC, Cause and Status;
  - ERET returns via EPC.
- Also owns the Count/Compare timer, samples external interrupt lines, and serves MFC0/MTC0.
- Its Status and Cause outputs feed back into the exception encoder for interrupt qualification.

Parameters:
- PRID, 32'h0001_8000, constant value returned for register 15 (PRId).
- COUNT_DIV, 2, clock cycles per Count increment (1 or 2).
- EXC_VECTOR, 32'hBFC0_0380, handler entry address.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- we_i  in  1  MTC0 write enable.
- waddr_i  in  5  MTC0 register number.
- raddr_i  in  5  MFC0 register number.
- wdata_i  in  32  MTC0 data.
- int_i  in  6  external hardware interrupt lines.
- excepttype_i  in  32  exception code from encoder (0 = none).
- pc_i  in  32  PC of the excepting instruction.
- is_in_delayslot_i  in  1  excepting instruction is in a branch delay slot.
- bad_addr_i  in  32  faulting address for AdEL/AdES.
- data_o  out  32  MFC0 read data.
- status_o  out  32  Status (reg 12).
- cause_o  out  32  Cause (reg 13).
- epc_o  out  32  EPC (reg 14).
- count_o  out  32  Count (reg 9).
- compare_o  out  32  Compare (reg 11).
- badvaddr_o  out  32  BadVAddr (reg 8).
- timer_int_o  out  1  timer interrupt pending.
- flush_o  out  1  pipeline flush (combinational, excepttype_i != 0).
- newpc_o  out  32  redirect target (combinational).

Behaviour:
- Reset (async, rst=1):
  - Status = 32'h0040_0000 (BEV=1).
  - Cause, EPC, BadVAddr, Count and Compare = 0.
  - timer_int_o = 0; divider phase = 0.
- Registered updates take effect on the rising clk edge. data_o is combinational from raddr_i.
- Write-to-read bypass: if we_i && waddr_i == raddr_i, data_o returns the masked value about to be written.
- Read map:
  - 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRID.
  - 16 Config = 32'h0000_0000.
  - All other numbers read 0.
- MTC0 write masks:
  - Status: only IM[15:8], EXL[1] and IE[0] are writable; BEV is hardwired to 1.
  - Cause: only IP[9:8] (software interrupts) are writable.
  - EPC, BadVAddr, Count and Compare: fully writable.
  - Writes to any other register number are ignored.
- Count: increments by 1 when the divider phase wraps, i.e. every COUNT_DIV cycles. Wraps 32'hFFFF_FFFF -> 0 silently.
- Count write: an MTC0 write to Count wins over the increment in the same cycle. Divider phase is unaffected.
- Timer:
  - Set: timer_int_o is set when Count == Compare and Compare != 0. It stays set until cleared.
  - Clear: any MTC0 write to Compare clears it; the clear wins over a match in the same cycle.
- Interrupt sampling, every cycle:
  - Cause[15:10] <= {int_i[5] | timer_int_o, int_i[4:0]}.
  - Cause[30] (TI) <= timer_int_o.
- Exception entry, when excepttype_i ∈ {1, 4, 5, 8, 9, 'ha, 'hc}:
  - Status.EXL <= 1.
  - Cause.ExcCode[6:2]: 1→0, 4→4, 5→5, 8→8, 9→9, 'ha→10, 'hc→12.
  - If EXL was already 1, EPC and BD are not updated.
  - Otherwise EPC <= is_in_delayslot_i ? pc_i-4 : pc_i, and Cause.BD[31] <= is_in_delayslot_i.
  - For codes 4 and 5: BadVAddr <= bad_addr_i.
- ERET (excepttype_i == 'he): Status.EXL <= 0; nothing else changes.
- Redirect (combinational): newpc_o = EPC for 'he, EXC_VECTOR for other nonzero codes, 0 when none.
  - For 'he, newpc_o uses EPC including a same-cycle MTC0 write to EPC (bypassed).
- Same-cycle MTC0 and exception: the MTC0 is applied first, then exception field updates override the fields they touch. Untouched fields keep the written value.
- Unknown nonzero excepttype_i: asserts flush_o and redirects to EXC_VECTOR; no register update.

Decomposition:
- Shared package `cp0_defs`:
  - register number constants (CP0_BADVADDR=8, ... CP0_CONFIG=16);
  - exception type codes (EXC_INT=1, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI='ha, EXC_OV='hc, EXC_ERET='he);
  - ExcCode values;
  - Status/Cause field bit positions and write masks.
- One natural sub-module: `cp0_timer`, containing the Count divider, Compare and timer_int.

Test Plan:
- Reset: rst=1 mid-run → status_o=32'h0040_0000, all other outputs 0, regardless of clock.
- Timer: MTC0 Compare=5, COUNT_DIV=2.
  - → count_o=5 after 10 cycles; timer_int_o=1 and cause_o[15]=1 one cycle later.
  - MTC0 Compare=20 → timer_int_o=0 next cycle.
- Syscall in delay slot: excepttype_i=8, pc_i=32'hBFC0_0104, is_in_delayslot_i=1.
  - → epc_o=32'hBFC0_0100, cause_o[31]=1, cause_o[6:2]=8, status_o[1]=1.
  - → same cycle: flush_o=1, newpc_o=32'hBFC0_0380.
- AdEL: excepttype_i=4, bad_addr_i=32'h8000_0003 → badvaddr_o=32'h8000_0003, ExcCode=4.
- Nested exception while EXL=1: overflow (code 'hc) → EPC unchanged, ExcCode=12.
- ERET: excepttype_i='he → newpc_o=epc_o, status_o[1]=0 next cycle.
- Write masks: MTC0 Status=32'hFFFF_FFFF → status_o=32'h0040_FF03.

Source files
------------

// File: rtl/cp0_defs.sv
// Shared CP0 definitions: register numbers, exception type codes, ExcCode values
// and Status/Cause field positions and write masks.
package cp0_defs;

   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;
   localparam logic [4:0] CP0_PRID     = 5'd15;
   localparam logic [4:0] CP0_CONFIG   = 5'd16;

   localparam logic [31:0] EXC_INT  = 32'h1;
   localparam logic [31:0] EXC_ADEL = 32'h4;
   localparam logic [31:0] EXC_ADES = 32'h5;
   localparam logic [31:0] EXC_SYS  = 32'h8;
   localparam logic [31:0] EXC_BP   = 32'h9;
   localparam logic [31:0] EXC_RI   = 32'ha;
   localparam logic [31:0] EXC_OV   = 32'hc;
   localparam logic [31:0] EXC_ERET = 32'he;

   localparam logic [4:0] EXCCODE_INT  = 5'd0;
   localparam logic [4:0] EXCCODE_ADEL = 5'd4;
   localparam logic [4:0] EXCCODE_ADES = 5'd5;
   localparam logic [4:0] EXCCODE_SYS  = 5'd8;
   localparam logic [4:0] EXCCODE_BP   = 5'd9;
   localparam logic [4:0] EXCCODE_RI   = 5'd10;
   localparam logic [4:0] EXCCODE_OV   = 5'd12;

   localparam int STATUS_IE  = 0;
   localparam int STATUS_EXL = 1;
   localparam int CAUSE_BD   = 31;
   localparam int CAUSE_TI   = 30;

   localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
   localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

   typedef struct packed {
      logic       take;
      logic [4:0] code;
      logic       badv;
   } exc_dec_t;

   function automatic exc_dec_t exc_decode(input logic [31:0] t);
      exc_dec_t d;
      d = '{take: 1'b1, code: EXCCODE_INT, badv: 1'b0};
      case (t)
         EXC_INT:  d.code = EXCCODE_INT;
         EXC_ADEL: begin d.code = EXCCODE_ADEL; d.badv = 1'b1; end
         EXC_ADES: begin d.code = EXCCODE_ADES; d.badv = 1'b1; end
         EXC_SYS:  d.code = EXCCODE_SYS;
         EXC_BP:   d.code = EXCCODE_BP;
         EXC_RI:   d.code = EXCCODE_RI;
         EXC_OV:   d.code = EXCCODE_OV;
         default:  d.take = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer: Count advances once every COUNT_DIV cycles and a sticky
// timer interrupt is raised on Count == Compare (Compare != 0).
module cp0_timer #(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_count_i,
   input  logic        we_compare_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        timer_int_o
);

   logic        phase_q, phase_d;
   logic        tick;
   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        tint_q, tint_d;

   always_comb begin
      phase_d   = (COUNT_DIV == 1) ? 1'b0 : ~phase_q;
      tick      = (COUNT_DIV == 1) ? 1'b1 : phase_q;
      count_d   = tick ? count_q + 32'd1 : count_q;
      compare_d = compare_q;
      tint_d    = tint_q;
      if (we_count_i) count_d = wdata_i;
      if (count_q == compare_q && compare_q != 32'd0) tint_d = 1'b1;
      // A Compare write acknowledges the interrupt, even against a fresh match.
      if (we_compare_i) begin
         compare_d = wdata_i;
         tint_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q   <= 1'b0;
         count_q   <= '0;
         compare_q <= '0;
         tint_q    <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         tint_q    <= tint_d;
      end
   end

   assign count_o     = count_q;
   assign compare_o   = compare_q;
   assign timer_int_o = tint_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: MFC0/MTC0 access, exception entry/ERET side effects,
// interrupt sampling and pipeline redirect.
module cp0_regfile
   import cp0_defs::*;
#(
   parameter logic [31:0] PRID       = 32'h0001_8000,
   parameter int          COUNT_DIV  = 2,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [4:0]  raddr_i,
   input  logic [31:0] wdata_i,
   input  logic [5:0]  int_i,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] pc_i,
   input  logic        is_in_delayslot_i,
   input  logic [31:0] bad_addr_i,
   output logic [31:0] data_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic [31:0] badvaddr_o,
   output logic        timer_int_o,
   output logic        flush_o,
   output logic [31:0] newpc_o
);

   logic [31:0] status_q, status_d, cause_q, cause_d;
   logic [31:0] epc_q, epc_d, badv_q, badv_d;
   logic [31:0] status_w, cause_w, epc_w, badv_w, count_w, compare_w;
   logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_badv;
   logic        eret;
   exc_dec_t    exc;

   assign wr_count   = we_i && (waddr_i == CP0_COUNT);
   assign wr_compare = we_i && (waddr_i == CP0_COMPARE);
   assign wr_status  = we_i && (waddr_i == CP0_STATUS);
   assign wr_cause   = we_i && (waddr_i == CP0_CAUSE);
   assign wr_epc     = we_i && (waddr_i == CP0_EPC);
   assign wr_badv    = we_i && (waddr_i == CP0_BADVADDR);

   cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
      .clk          (clk),
      .rst          (rst),
      .we_count_i   (wr_count),
      .we_compare_i (wr_compare),
      .wdata_i      (wdata_i),
      .count_o      (count_o),
      .compare_o    (compare_o),
      .timer_int_o  (timer_int_o)
   );

   // Register values with this cycle's MTC0 applied; serve both the bypassed
   // read port and the base for exception field overrides.
   assign status_w  = wr_status  ? ((wdata_i & STATUS_WMASK) | STATUS_RESET) : status_q;
   assign cause_w   = wr_cause   ? ((cause_q & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK)) : cause_q;
   assign epc_w     = wr_epc     ? wdata_i : epc_q;
   assign badv_w    = wr_badv    ? wdata_i : badv_q;
   assign count_w   = wr_count   ? wdata_i : count_o;
   assign compare_w = wr_compare ? wdata_i : compare_o;

   assign exc  = exc_decode(excepttype_i);
   assign eret = (excepttype_i == EXC_ERET);

   always_comb begin
      status_d = status_w;
      cause_d  = cause_w;
      epc_d    = epc_w;
      badv_d   = badv_w;
      cause_d[15:10]   = {int_i[5] | timer_int_o, int_i[4:0]};
      cause_d[CAUSE_TI] = timer_int_o;
      if (exc.take) begin
         status_d[STATUS_EXL] = 1'b1;
         cause_d[6:2]         = exc.code;
         if (!status_w[STATUS_EXL]) begin
            epc_d             = is_in_delayslot_i ? pc_i - 32'd4 : pc_i;
            cause_d[CAUSE_BD] = is_in_delayslot_i;
         end
         if (exc.badv) badv_d = bad_addr_i;
      end else if (eret) begin
         status_d[STATUS_EXL] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_q <= STATUS_RESET;
         cause_q  <= '0;
         epc_q    <= '0;
         badv_q   <= '0;
      end else begin
         status_q <= status_d;
         cause_q  <= cause_d;
         epc_q    <= epc_d;
         badv_q   <= badv_d;
      end
   end

   always_comb begin
      case (raddr_i)
         CP0_BADVADDR: data_o = badv_w;
         CP0_COUNT:    data_o = count_w;
         CP0_COMPARE:  data_o = compare_w;
         CP0_STATUS:   data_o = status_w;
         CP0_CAUSE:    data_o = cause_w;
         CP0_EPC:      data_o = epc_w;
         CP0_PRID:     data_o = PRID;
         default:      data_o = 32'h0;
      endcase
   end

   assign flush_o    = (excepttype_i != 32'h0);
   assign newpc_o    = eret ? epc_w : (flush_o ? EXC_VECTOR : 32'h0);
   assign status_o   = status_q;
   assign cause_o    = cause_q;
   assign epc_o      = epc_q;
   assign badvaddr_o = badv_q;

endmodule
